// File: rtl/aes_dec_arbiter.sv
// Round-robin arbiter sharing one AES decryption engine between two requesters.
// Optional engine-done watchdog enabled by defining AES_DEC_ARB_TIMEOUT_EN.
module aes_dec_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [127:0] req0_data,
  input  logic [127:0] req1_data,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         busy,
  output logic         eng_valid,
  output logic [127:0] eng_datain,
  output logic [127:0] eng_key,
  input  logic         eng_done,
  input  logic [127:0] eng_dataout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic ptr;
  logic winner;
  logic win;
  logic grant;
  logic done_ok;
  logic timeout;

  // Pointer only matters when both request; a lone requester always wins.
  assign win = (req0_valid & req1_valid) ? ptr : req1_valid;

  assign done_ok = (state == WAIT) & eng_done;

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // Terminal count is the last WAIT cycle; eng_done there still wins.
  assign timeout = (state == WAIT) & ~eng_done & (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if ((state == WAIT) && !eng_done && !timeout) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (done_ok) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign resp_err   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done_ok || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      winner     <= 1'b0;
      eng_datain <= '0;
      eng_key    <= '0;
    end else if (grant) begin
      ptr        <= ~win;
      winner     <= win;
      eng_datain <= win ? req1_data : req0_data;
      eng_key    <= win ? req1_key : req0_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
    end else if (done_ok) begin
      resp_data <= eng_dataout;
    end else if (timeout) begin
      resp_data <= '0;
    end
  end

  assign busy        = (state != IDLE);
  assign eng_valid   = (state == ISSUE);
  assign req0_ready  = (state == ISSUE) & ~winner;
  assign req1_ready  = (state == ISSUE) & winner;
  assign resp0_valid = (state == RESP) & ~winner;
  assign resp1_valid = (state == RESP) & winner;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed bench for aes_dec_arbiter with a behavioural engine model.
// Timeout scenarios run only when AES_DEC_ARB_TIMEOUT_EN is defined.
module tb_aes_dec_arbiter;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D1   = 128'h00000000111111112222222233333333;
  localparam logic [127:0] K1   = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] P1   = 128'hffffffffeeeeeeeeddddddddcccccccc;
  localparam logic [127:0] XD   = 128'hdeadbeef0badf00dcafef00d12345678;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [127:0] req0_data = '0;
  logic [127:0] req1_data = '0;
  logic [127:0] req0_key = '0;
  logic [127:0] req1_key = '0;
  logic         req0_ready;
  logic         req1_ready;
  logic         resp0_valid;
  logic         resp1_valid;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         busy;
  logic         eng_valid;
  logic [127:0] eng_datain;
  logic [127:0] eng_key;
  logic         eng_done;
  logic [127:0] eng_dataout;

  logic         manual = 1'b0;
  logic         man_done = 1'b0;
  logic [127:0] man_data = '0;
  logic         stall = 1'b0;
  logic         mdl_done;
  logic [127:0] mdl_data;
  int           e_cnt;
  int           cyc = 0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_data(req0_data),
    .req1_data(req1_data),
    .req0_key(req0_key),
    .req1_key(req1_key),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .resp0_valid(resp0_valid),
    .resp1_valid(resp1_valid),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .busy(busy),
    .eng_valid(eng_valid),
    .eng_datain(eng_datain),
    .eng_key(eng_key),
    .eng_done(eng_done),
    .eng_dataout(eng_dataout)
  );

  // Engine model: FIPS-197 vector decrypts properly, anything else is data^key.
  function automatic logic [127:0] decrypt(input logic [127:0] d,
                                           input logic [127:0] k);
    if (d == CT0 && k == KEY0) return PT0;
    return d ^ k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt    <= 0;
      mdl_done <= 1'b0;
      mdl_data <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (eng_valid) begin
        e_cnt <= LAT;
      end else if (e_cnt != 0) begin
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1 && !stall) begin
          mdl_done <= 1'b1;
          mdl_data <= decrypt(eng_datain, eng_key);
        end
      end
    end
  end

  assign eng_done    = manual ? man_done : mdl_done;
  assign eng_dataout = manual ? man_data : mdl_data;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic await_grant(input int id, input bit drop, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    check({tag, "_grant_seen"}, 128'(got), 128'(1));
    check({tag, "_grant_id"}, 128'({req1_ready, req0_ready}),
          (id == 1) ? 128'(2'b10) : 128'(2'b01));
    check({tag, "_eng_valid"}, 128'(eng_valid), 128'(1));
    if (drop) begin
      if (req0_ready) req0_valid = 1'b0;
      if (req1_ready) req1_valid = 1'b0;
    end
  endtask

  task automatic await_resp(input int id, input logic [127:0] exp,
                            input logic err, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) got = 1'b1;
    end
    check({tag, "_resp_seen"}, 128'(got), 128'(1));
    check({tag, "_resp_id"}, 128'({resp1_valid, resp0_valid}),
          (id == 1) ? 128'(2'b10) : 128'(2'b01));
    check({tag, "_resp_data"}, resp_data, exp);
    check({tag, "_resp_err"}, 128'(resp_err), 128'(err));
  endtask

  initial begin
    int t0;
    int nresp;
    logic bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", 128'({req0_ready, req1_ready, resp0_valid,
          resp1_valid, resp_err, busy, eng_valid}), 128'(0));
    check("rst_datain", eng_datain, 128'(0));
    check("rst_key", eng_key, 128'(0));
    check("rst_resp_data", resp_data, 128'(0));
    rst_n = 1'b1;

    // FIPS-197 single request; latency: decide, issue, LAT+1 wait, resp
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = CT0;
    req0_key   = KEY0;
    t0 = cyc;
    @(negedge clk);
    check("fips_ready0", 128'(req0_ready), 128'(1));
    check("fips_ready1", 128'(req1_ready), 128'(0));
    check("fips_eng_valid", 128'(eng_valid), 128'(1));
    check("fips_datain", eng_datain, CT0);
    check("fips_key", eng_key, KEY0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("fips_pulse", 128'({req0_ready, eng_valid}), 128'(0));
    check("fips_busy", 128'(busy), 128'(1));
    await_resp(0, PT0, 1'b0, "fips");
    check("fips_latency", 128'(cyc - t0), 128'(7));
    @(negedge clk);
    check("fips_idle", 128'({resp0_valid, busy}), 128'(0));
    check("fips_hold", resp_data, PT0);

    // Round robin from reset: 0, then 1, then 0 again
    do_reset();
    req0_valid = 1'b1;
    req0_data  = CT0;
    req0_key   = KEY0;
    req1_valid = 1'b1;
    req1_data  = D1;
    req1_key   = K1;
    await_grant(0, 1'b1, "rr_a");
    check("rr_a_key_stable", eng_key, KEY0);
    await_resp(0, PT0, 1'b0, "rr_a");
    await_grant(1, 1'b1, "rr_b");
    await_resp(1, P1, 1'b0, "rr_b");
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    await_grant(0, 1'b1, "rr_c");
    await_resp(0, PT0, 1'b0, "rr_c");
    await_grant(1, 1'b1, "rr_d");
    await_resp(1, P1, 1'b0, "rr_d");

    // eng_done in IDLE is ignored
    @(negedge clk);
    manual   = 1'b1;
    man_done = 1'b1;
    man_data = XD;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) bad = 1'b1;
    end
    check("idle_done_ignored", 128'(bad), 128'(0));
    check("idle_done_data", resp_data, P1);
    man_done = 1'b0;
    manual   = 1'b0;

    // Reset five cycles into WAIT with request held
    stall      = 1'b1;
    req0_valid = 1'b1;
    req0_data  = CT0;
    req0_key   = KEY0;
    await_grant(0, 1'b0, "mid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 128'({req0_ready, req1_ready, resp0_valid,
          resp1_valid, resp_err, busy, eng_valid}), 128'(0));
    check("mid_rst_data", {eng_datain ^ eng_key ^ resp_data}, 128'(0));
    check("mid_rst_key", eng_key, 128'(0));
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    await_grant(0, 1'b1, "mid_re");
    nresp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp0_valid) begin
        nresp++;
        check("mid_re_data", resp_data, PT0);
      end
      if (resp1_valid) nresp += 100;
    end
    check("mid_re_count", 128'(nresp), 128'(1));

`ifdef AES_DEC_ARB_TIMEOUT_EN
    // Stalled engine: eight WAIT cycles then error response
    stall      = 1'b1;
    req0_valid = 1'b1;
    req0_data  = D1;
    req0_key   = K1;
    await_grant(0, 1'b1, "to");
    t0 = cyc;
    await_resp(0, 128'(0), 1'b1, "to");
    check("to_wait_len", 128'(cyc - t0), 128'(9));
    manual   = 1'b1;
    man_done = 1'b1;
    man_data = XD;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) bad = 1'b1;
    end
    check("to_late_ignored", 128'(bad), 128'(0));
    check("to_late_err", 128'(resp_err), 128'(1));
    check("to_late_data", resp_data, 128'(0));
    man_done = 1'b0;
    stall    = 1'b0;

    // eng_done on the terminal-count cycle wins
    req0_valid = 1'b1;
    await_grant(0, 1'b1, "tc");
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp0_valid || !busy) bad = 1'b1;
    end
    check("tc_still_wait", 128'(bad), 128'(0));
    man_done = 1'b1;
    man_data = XD;
    @(negedge clk);
    man_done = 1'b0;
    check("tc_resp", 128'(resp0_valid), 128'(1));
    check("tc_err", 128'(resp_err), 128'(0));
    check("tc_data", resp_data, XD);
    manual = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_dec_arbiter.md
AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning engine-done watchdog limit in clk cycles (used only when AES_DEC_ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1 each  requester N has a block pending; held high until reqN_ready.
REQ-005 The block SHALL have ports req0_data, req1_data  input  128 each  ciphertext from requester N.
REQ-006 The block SHALL have ports req0_key, req1_key  input  128 each  cipher key from requester N.
REQ-007 The block SHALL have ports req0_ready, req1_ready  output  1 each  one-cycle accept pulse to requester N.
REQ-008 The block SHALL have ports resp0_valid, resp1_valid  output  1 each  one-cycle result pulse to requester N.
REQ-009 The block SHALL have port resp_data  output  128  registered plaintext result, shared by both requesters.
REQ-010 The block SHALL have port resp_err  output  1  qualifies respN_valid; 1 = timeout, no valid result.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have ports eng_valid  output  1, eng_datain  output  128 and eng_key  output  128, which drive the shared decryption engine's start pulse, ciphertext and key.
REQ-013 The block SHALL have ports eng_done  input  1 and eng_dataout  input  128, which carry the engine's one-cycle completion pulse and its plaintext.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-015 In IDLE with any reqN_valid high, the FSM SHALL select the winner, latch its data and key into eng_datain/eng_key, record the winner ID, and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer names the favoured requester; if both request, the favoured one wins; if only one requests, it wins regardless of the pointer.
REQ-017 After each grant the pointer SHALL point to the non-winning requester.
REQ-018 ISSUE SHALL last exactly one cycle, with eng_valid=1 and reqN_ready=1 for the winner only; the next state SHALL be WAIT.
REQ-019 eng_valid SHALL never be high outside ISSUE, because the engine reloads whenever valid is high.
REQ-020 eng_datain and eng_key SHALL stay stable from ISSUE until the block returns to IDLE.
REQ-021 In WAIT, on eng_done=1 the block SHALL register eng_dataout into resp_data, clear resp_err, and move to RESP.
REQ-022 RESP SHALL last one cycle, with respN_valid=1 for the recorded winner only; the next state SHALL be IDLE.
REQ-023 resp_data and resp_err SHALL hold their values until the next RESP.
REQ-024 eng_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 Minimum request-to-response latency SHALL be engine latency + 3 cycles (IDLE decision, ISSUE, RESP).
REQ-026 A requester SHALL be granted again no earlier than the IDLE cycle after its RESP.
REQ-027 Changes on req inputs during ISSUE, WAIT or RESP SHALL have no effect on the operation in flight.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously go to IDLE, set the pointer to requester 0, and clear reqN_ready, respN_valid, resp_err, busy, eng_valid, eng_datain, eng_key, resp_data and the timeout counter to 0.
REQ-029 Reset mid-operation SHALL abandon the transaction; no respN_valid SHALL be issued for it after reset release.
REQ-030 After rst_n rises, the block SHALL evaluate requests from the first rising clk edge.

Configuration
REQ-031 With macro AES_DEC_ARB_TIMEOUT_EN defined, the block SHALL clear a counter on entry to WAIT and increment it each WAIT cycle without eng_done.
REQ-032 With AES_DEC_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL go to RESP with resp_err=1 and resp_data=0; a late eng_done SHALL then be ignored.
REQ-033 With AES_DEC_ARB_TIMEOUT_EN defined, eng_done in the terminal-count cycle SHALL win, giving a normal response with resp_err=0.
REQ-034 Without AES_DEC_ARB_TIMEOUT_EN, no counter SHALL exist, resp_err SHALL be tied 0, and WAIT SHALL last until eng_done.

Verification
REQ-035 The bench SHALL cover: reset, req0 alone with key=000102..0f and the matching FIPS-197 ciphertext -> req0_ready one cycle, eng_valid in the same cycle, resp0_valid with resp_data=00112233445566778899aabbccddeeff and resp_err=0.
REQ-036 The bench SHALL cover: req0 and req1 asserted on the same cycle after reset -> req0 served first, then req1, then on the next simultaneous pair req0 again.
REQ-037 The bench SHALL cover: eng_done forced high in IDLE -> no respN_valid, state stays IDLE.
REQ-038 The bench SHALL cover: rst_n pulled low 5 cycles into WAIT, req held -> all outputs 0, then after release a fresh ISSUE, exactly one resp0_valid.
REQ-039 The bench SHALL cover, with AES_DEC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8 and the engine stalled -> resp0_valid, resp_err=1, resp_data=0 after 8 WAIT cycles, and a late eng_done ignored.
REQ-040 The bench SHALL cover, with AES_DEC_ARB_TIMEOUT_EN and eng_done on the terminal-count cycle -> resp_err=0 and correct resp_data.
